mem_bus_master: RTL
===================

MEM_BUS_MASTER -- requirements
Module: mem_bus_master

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 128: number of valid word addresses (0 .. MEM_DEPTH-1).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 1: number of cycles CS is held per access (legal range 1-15).
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST_N  input  1  synchronous, active-low reset, sampled on rising CLK.
REQ-005 req_valid  input  1  requester has a transaction.
REQ-006 req_ready  output  1  block accepts a request this cycle.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  32  word address.
REQ-009 req_wdata  input  32  write data.
REQ-010 resp_valid  output  1  response available.
REQ-011 resp_ready  input  1  requester consumes the response.
REQ-012 resp_rdata  output  32  read data (0 for writes and errors).
REQ-013 resp_err  output  1  address out of range.
REQ-014 CS  output  1  memory chip select, active high.
REQ-015 WE  output  1  memory write enable, active high.
REQ-016 ADDR  output  32  memory word address.
REQ-017 Mem_Bus  inout  32  shared data bus to memory.

Function
REQ-018 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; a handshake occurs when req_valid and req_ready are both 1 on a rising edge.
REQ-020 On handshake, req_we, req_addr and req_wdata SHALL be latched; subsequent input changes are ignored until the next IDLE.
REQ-021 On handshake with req_addr < MEM_DEPTH, the next state SHALL be ACCESS with the wait counter loaded to WAIT_CYCLES-1.
REQ-022 On handshake with req_addr >= MEM_DEPTH, the next state SHALL be RESP with resp_err=1 and resp_rdata=0; CS SHALL never assert for that transaction.
REQ-023 In ACCESS, CS=1, WE=latched we, and ADDR=latched address SHALL hold, all constant for exactly WAIT_CYCLES cycles.
REQ-024 In ACCESS with we=1, Mem_Bus SHALL be driven with the latched wdata; in all other states and for reads, Mem_Bus SHALL be high-Z.
REQ-025 In ACCESS, the wait counter SHALL decrement each cycle; when it is 0, the next state SHALL be RESP.
REQ-026 For reads, resp_rdata SHALL capture Mem_Bus on the rising edge that leaves ACCESS, i.e. after the memory's falling-edge read.
REQ-027 For writes, resp_rdata SHALL be 0 and resp_err SHALL be 0.
REQ-028 In RESP, resp_valid=1 SHALL hold with resp_rdata and resp_err stable until resp_ready=1; the next state is then IDLE.
REQ-029 Minimum request-to-resp_valid latency SHALL be WAIT_CYCLES+1 cycles; error latency SHALL be 1 cycle.
REQ-030 Back-to-back throughput SHALL be one transaction per WAIT_CYCLES+2 cycles; there is no request queue.
REQ-031 CS=0 and WE=0 SHALL hold in IDLE and RESP; WE SHALL never be 1 while CS=0.
REQ-032 ADDR SHALL hold its last value outside ACCESS.

Reset
REQ-033 When RST_N=0 at a rising edge, the state SHALL go to IDLE with req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, CS=0, WE=0, ADDR=0, and Mem_Bus high-Z.
REQ-034 Reset during ACCESS SHALL abort the transaction without a response; a write in that cycle may already have committed at the preceding falling edge.
REQ-035 Reset during RESP SHALL discard the pending response.

Verification
REQ-036 Write then read: write addr 5, data 0xDEADBEEF (WAIT_CYCLES=1), then read addr 5 -> CS high 1 cycle each; read resp_rdata=0xDEADBEEF, resp_err=0; write resp_rdata=0.
REQ-037 Out of range: read addr 128 -> resp_valid 1 cycle after handshake, resp_err=1, resp_rdata=0, CS stays 0.
REQ-038 Wait states: WAIT_CYCLES=3, read addr 0 -> CS high exactly 3 cycles; resp_valid at cycle 4.
REQ-039 Backpressure: resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stable; req_ready=0 throughout; IDLE follows the first resp_ready=1.
REQ-040 Reset mid-access: RST_N=0 during a write's ACCESS cycle -> next cycle CS=0, Mem_Bus=Z, resp_valid=0, req_ready=1.
REQ-041 Bus discipline: randomized reads and writes -> Mem_Bus is never driven by the block while WE=0, and a checker asserts WE implies CS.

Source files
------------

// File: rtl/mem_bus_master.sv
// mem_bus_master: single-outstanding request/response master for a wait-stated shared-bus memory
module mem_bus_master #(
   parameter int unsigned MEM_DEPTH   = 128,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        CS,
   output logic        WE,
   output logic [31:0] ADDR,
   inout  wire  [31:0] Mem_Bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);
   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic        err_q, err_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        in_range;
   assign in_range = req_addr < MEM_DEPTH;
   // the block only drives the shared bus while a write access is in progress
   assign Mem_Bus = WE ? wdata_q : 32'bz;
   // next-state and output decode; ADDR only moves when an in-range access starts
   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      err_d      = err_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      req_ready  = state_q == IDLE;
      resp_valid = state_q == RESP;
      CS         = state_q == ACCESS;
      WE         = state_q == ACCESS && we_q;
      ADDR       = addr_q;
      resp_rdata = rdata_q;
      resp_err   = err_q;
      case (state_q)
         IDLE: if (req_valid) begin
            we_d    = req_we;
            wdata_d = req_wdata;
            rdata_d = '0;
            err_d   = !in_range;
            if (in_range) begin
               addr_d  = req_addr;
               cnt_d   = CNT_LOAD;
               state_d = ACCESS;
            end else begin
               state_d = RESP;
            end
         end
         ACCESS: if (cnt_q == 4'd0) begin
            rdata_d = we_q ? 32'd0 : Mem_Bus;
            state_d = RESP;
         end else begin
            cnt_d = cnt_q - 4'd1;
         end
         RESP: state_d = resp_ready ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
   end
   // state register with synchronous active-low reset
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end
endmodule
